triggered_trigger_receiver: RTL
===============================

# triggered_trigger_receiver

Receiving end of the triggered-readout trigger line: samples an asynchronous trigger input and qualifies each pulse against a minimum length. Each accepted pulse is recorded as a FIFO entry holding the rising-edge timestamp, the measured width and a sequence number. It sits beside the readout timestamp logic and feeds trigger records to the readout packer through a valid/ready port.

## Interface
- `FIFO_DEPTH`, 8, entries in the record FIFO; power of two, ≥2
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `triggerin`  in  1  external trigger, asynchronous to `clock`
- `timestamp`  in  10  free-running readout timestamp
- `enable`  in  1  arms reception
- `minlength`  in  8  minimum accepted high time = {minlength, 4'b0} cycles
- `clear_counter`  in  1  clears `triggercount`, `overflow`, sequence
- `rec_data`  out  32  [31:16] width, [15:10] sequence, [9:0] rising-edge timestamp
- `rec_valid`  out  1  FIFO non-empty
- `rec_ready`  in  1  consumer pops head when `rec_valid && rec_ready`
- `triggercount`  out  16  accepted pulses, wraps at 0xFFFF→0
- `overflow`  out  1  sticky; accepted pulse dropped due to full FIFO
- `busy`  out  1  FSM not in IDLE

## Operation
- `triggerin` passes through a 2-flop synchronizer; edges are detected on the synchronized signal `trig_s`.
- FSM states:
  - ARM: entered on reset release and whenever `enable` rises. Waits for `trig_s`=0, then goes to IDLE. A pulse already high at arming is never recorded.
  - IDLE: on a `trig_s` rising edge with `enable`=1, latch `timestamp`, set width=1 and go to MEASURE. With `enable`=0, stay in IDLE.
  - MEASURE: width increments each cycle `trig_s`=1, saturating at 0xFFFF. On the falling edge:
    - if width ≥ {minlength,4'b0}: commit and return to IDLE;
    - otherwise discard silently and return to IDLE.
    - Deasserting `enable` mid-pulse does not abort the measurement.
- Commit:
  - `triggercount` increments.
  - Sequence = low 6 bits of `triggercount` before the increment.
  - The record is pushed to the FIFO.
- FIFO full at commit:
  - with a pop in the same cycle, the push is accepted;
  - otherwise the record is dropped, `overflow` is set, and `triggercount` still increments.
- `clear_counter`:
  - when coincident with a commit, clear wins: `triggercount`=0, sequence stored = 0.
  - It does not flush the FIFO.
- `minlength`=0 accepts every pulse, including 1-cycle pulses.
- Reset values: `rec_valid`=0, `rec_data`=0, `triggercount`=0, `overflow`=0, `busy`=1 (ARM), FIFO empty. Reset asserted mid-pulse discards the pulse and FIFO contents.

## Timing
- Pad edge to detection: 2–3 cycles (synchronizer).
- The timestamp is sampled in the cycle the synchronized rising edge is detected.
- Width equals the `trig_s` high cycle count: a pulse held for N whole cycles gives width N.
- The commit happens in the falling-edge detect cycle; `rec_valid` rises the following cycle.
- `triggercount` updates in that same following cycle.
- FIFO is first-word-fall-through: `rec_data` is stable while `rec_valid && !rec_ready`, and the next entry appears the cycle after a pop.
- A back-to-back low gap of 1 synchronized cycle is sufficient to separate two pulses.

## Structure
- Shared package `triggered_readout_pkg` holds:
  - FSM state encoding (ARM, IDLE, MEASURE);
  - record field offsets and widths (WIDTH_LSB=16, SEQ_LSB=10, TS_WIDTH=10);
  - `REC_WIDTH`=32.
- Sub-module `trigger_rx_fifo`: parameterized synchronous FWFT FIFO with push/pop/full/empty and the simultaneous push-pop-on-full rule. Synchronizer and FSM stay in the top module.

## Test plan
- `minlength`=2, 40-cycle pulse at `timestamp`=0x155 → one record {0x0028, 6'd0, 0x155}; `triggercount`=1.
- `minlength`=2, 20-cycle pulse → no record; `triggercount`=0; `busy` returns to 0.
- `FIFO_DEPTH`=4, `rec_ready`=0, `minlength`=1, five 16-high/32-low pulses → 4 records with sequence 0–3; `overflow`=1; `triggercount`=5. Then drain: records come out in order.
- `triggerin` high when `enable` rises, then low, then a 30-cycle pulse (`minlength`=1) → exactly one record with width 30.
- Pulse held 70000 cycles → width 0xFFFF. `clear_counter` in the commit cycle → `triggercount`=0 and record sequence 0.
- Reset asserted mid-pulse with 2 records queued → all outputs at reset values. Input still high at release → ARM, no record from that pulse.

Source files
------------

// File: rtl/triggered_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : triggered_readout_pkg
// Brief    : Shared FSM encoding and trigger-record layout for the readout path
// Revision : 1.0
// ============================================================================
package triggered_readout_pkg;

    localparam int REC_WIDTH = 32;
    localparam int WIDTH_LSB = 16;
    localparam int SEQ_LSB   = 10;
    localparam int TS_WIDTH  = 10;
    localparam int SEQ_WIDTH = 6;
    localparam int CNT_WIDTH = 16;

    localparam logic [1:0] ST_ARM     = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    function automatic logic [REC_WIDTH-1:0] pack_record(
        input logic [CNT_WIDTH-1:0] width,
        input logic [SEQ_WIDTH-1:0] seq,
        input logic [TS_WIDTH-1:0]  ts
    );
        logic [REC_WIDTH-1:0] rec;
        rec                          = '0;
        rec[TS_WIDTH-1:0]            = ts;
        rec[SEQ_LSB +: SEQ_WIDTH]    = seq;
        rec[WIDTH_LSB +: CNT_WIDTH]  = width;
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trigger_rx_fifo
// Brief    : Synchronous first-word-fall-through FIFO; push accepted on full
//            when a pop happens in the same cycle
// Revision : 1.0
// ============================================================================
module trigger_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int                  c_addr_w     = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_full_count = (c_addr_w + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_full_count);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Head is forced to zero while empty so the output is defined after reset.
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_addr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_addr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/triggered_trigger_receiver.sv
`default_nettype none
// ============================================================================
// Module   : triggered_trigger_receiver
// Brief    : Synchronizes the trigger line, qualifies pulse length and queues
//            timestamped trigger records for the readout packer
// Revision : 1.0
// ============================================================================
module triggered_trigger_receiver
    import triggered_readout_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 triggerin,
    input  logic [TS_WIDTH-1:0]  timestamp,
    input  logic                 enable,
    input  logic [7:0]           minlength,
    input  logic                 clear_counter,
    output logic [REC_WIDTH-1:0] rec_data,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [CNT_WIDTH-1:0] triggercount,
    output logic                 overflow,
    output logic                 busy
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_trig_d;
    logic                 r_enable_d;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_width;
    logic [TS_WIDTH-1:0]  r_ts;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;

    logic                 w_trig_s;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_enable_rise;
    logic [CNT_WIDTH-1:0] w_min_width;
    logic                 w_commit;
    logic                 w_drop;
    logic [SEQ_WIDTH-1:0] w_seq;
    logic [REC_WIDTH-1:0] w_record;
    logic                 w_full;
    logic                 w_empty;

    assign w_trig_s      = r_sync2;
    assign w_rise        = w_trig_s && !r_trig_d;
    assign w_fall        = !w_trig_s && r_trig_d;
    assign w_enable_rise = enable && !r_enable_d;
    assign w_min_width   = {4'b0000, minlength, 4'b0000};
    assign w_commit      = (r_state == ST_MEASURE) && !w_enable_rise && w_fall
                           && (r_width >= w_min_width);
    // Full implies non-empty, so rec_ready alone means a pop this cycle.
    assign w_drop        = w_commit && w_full && !rec_ready;
    assign w_seq         = clear_counter ? '0 : r_count[SEQ_WIDTH-1:0];
    assign w_record      = pack_record(r_width, w_seq, r_ts);

    assign rec_valid     = !w_empty;
    assign triggercount  = r_count;
    assign overflow      = r_overflow;
    assign busy          = (r_state != ST_IDLE);

    // Synchronizer resets high so a line already high at release is seen as
    // high, keeping ARM waiting instead of reporting a false rising edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_trig_d   <= 1'b1;
            r_enable_d <= 1'b0;
        end else begin
            r_sync1    <= triggerin;
            r_sync2    <= r_sync1;
            r_trig_d   <= w_trig_s;
            r_enable_d <= enable;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ARM;
            r_width <= '0;
            r_ts    <= '0;
        end else if (w_enable_rise) begin
            r_state <= ST_ARM;
        end else begin
            case (r_state)
                ST_ARM: begin
                    if (!w_trig_s) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_rise && enable) begin
                        r_ts    <= timestamp;
                        r_width <= 16'd1;
                        r_state <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_trig_s) begin
                        if (r_width != 16'hFFFF) r_width <= r_width + 16'd1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear_counter) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_commit) r_count    <= r_count + 16'd1;
            if (w_drop)   r_overflow <= 1'b1;
        end
    end

    trigger_rx_fifo #(
        .DATA_WIDTH (REC_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (w_commit),
        .push_data  (w_record),
        .pop        (rec_ready),
        .pop_data   (rec_data),
        .full       (w_full),
        .empty      (w_empty)
    );

endmodule
`default_nettype wire
